add_seq16: RTL and testbench

ADD_SEQ16 -- requirements
Module: add_seq16

---
 rtl/add_pkg.sv | 12 +
 rtl/add_seq16_add4.sv | 35 +++
 rtl/add_seq16.sv | 120 ++++++++++++
 tb/tb_add_seq16.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_pkg.sv
// Shared definitions for the nibble-serial adder: FSM states and slice width.
package add_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add_seq16_add4.sv
// 4-bit ripple-carry adder built from single-bit full-adder cells.
module fadd (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module add4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        fadd u_fadd (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    assign cout = c[4];
endmodule

// File: rtl/add_seq16.sv
// Nibble-serial W-bit adder: one add4 slice reused for NIBBLES cycles, LSB nibble first.
module add_seq16 #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic                   busy
);
    import add_pkg::*;

    localparam int W  = SLICE_W * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // in_valid/a/b/cin must hold until accepted; sum/cout stay frozen while
    // out_valid && !out_ready. in_ready may be high in DONE when out_ready is
    // high, so a result can be consumed and a new request taken on one edge.

    state_t          state;
    state_t          state_nxt;
    logic            accept;
    logic            last;

    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            carry_q;
    logic [IW-1:0]   idx;

    logic [SLICE_W-1:0] a_nib;
    logic [SLICE_W-1:0] b_nib;
    logic [SLICE_W-1:0] s_nib;
    logic               c_nib;

    assign last = (idx == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    in_ready  = 1'b1;
                    state_nxt = in_valid ? RUN : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN);

    assign a_nib = a_q[SLICE_W*idx +: SLICE_W];
    assign b_nib = b_q[SLICE_W*idx +: SLICE_W];

    add4 u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .s    (s_nib),
        .cout (c_nib)
    );

    // Accept only happens in IDLE/DONE, so it never collides with a RUN step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx     <= '0;
        end else if (state == RUN) begin
            sum[SLICE_W*idx +: SLICE_W] <= s_nib;
            carry_q <= c_nib;
            if (last) begin
                idx  <= '0;
                cout <= c_nib;
            end else begin
                idx  <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_add_seq16.sv
// Bench for add_seq16: directed corner cases plus randomized traffic against a transaction-level model.
module tb_add_seq16;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          cin = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  sum;
    logic          cout;
    logic          busy;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    add_seq16 #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // A job is "in flight" for NIBBLES cycles after acceptance, then its
    // result a+b+cin is on offer until the consumer takes it.
    typedef enum int {M_IDLE, M_RUN, M_DONE} mphase_t;
    mphase_t      m_ph = M_IDLE;
    int           m_left = 0;
    logic [W:0]   m_pending = '0;
    logic [W:0]   m_res = '0;
    logic [W:0]   exp_q[$];

    task automatic start_job();
        m_pending = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        exp_q.push_back(m_pending);
        m_ph   = M_RUN;
        m_left = NIBBLES;
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_ph  = M_IDLE;
            m_res = '0;
            exp_q.delete();
        end else begin
            case (m_ph)
                M_IDLE: if (in_valid) start_job();
                M_RUN: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_ph  = M_DONE;
                        m_res = m_pending;
                    end
                end
                M_DONE: begin
                    if (out_ready) begin
                        if (in_valid) start_job();
                        else m_ph = M_IDLE;
                    end
                end
                default: m_ph = M_IDLE;
            endcase
        end
    end

    // ---------------- per-cycle compare + scoreboard ----------------
    int n_results = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", in_ready, (m_ph == M_IDLE) || (m_ph == M_DONE && out_ready));
            check("out_valid", out_valid, m_ph == M_DONE);
            check("busy", busy, m_ph == M_RUN);
            if (m_ph != M_RUN)
                check("result_hold", {cout, sum}, m_res);
            if (out_valid && out_ready && rst_n) begin
                check("sb_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    check("sb_result", {cout, sum}, exp_q.pop_front());
                    n_results++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic cc);
        int n;
        a = aa; b = bb; cin = cc; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check("done_wait", out_valid, 1);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return '1;
            1: return '0;
            2: return W'(16'h0001);
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int lat, lat2, r1, r2;

        // reset with a request pending: must not be accepted
        rst_n = 1'b0; in_valid = 1'b1; a = 16'h1234; b = 16'h4321;
        repeat (3) tick();
        rst_n = 1'b1; in_valid = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", sum, 16'h0000);
        check("rst_cout", cout, 0);

        out_ready = 1'b1;

        // carry into the second nibble, fixed latency
        send(16'h00FF, 16'h0001, 1'b0);
        wait_done(lat);
        check("lat_00ff", lat, NIBBLES);
        check("sum_00ff", sum, 16'h0100);
        check("cout_00ff", cout, 0);
        tick();

        // full ripple through every nibble
        send(16'hFFFF, 16'h0000, 1'b1);
        wait_done(lat);
        check("sum_ffff", sum, 16'h0000);
        check("cout_ffff", cout, 1);
        tick();

        // back-to-back: second request taken on the edge that consumes the first
        a = 16'd1; b = 16'd2; cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        check("b2b_ready0", in_ready, 1);
        tick();
        a = 16'd3; b = 16'd4;
        wait_done(lat);
        r1 = cyc;
        check("b2b_sum1", sum, 16'd3);
        check("b2b_ready_done", in_ready, 1);
        tick();
        in_valid = 1'b0;
        wait_done(lat2);
        r2 = cyc;
        check("b2b_lat2", lat2, NIBBLES);
        check("b2b_sum2", sum, 16'd7);
        check("b2b_period", r2 - r1, 5);
        tick();

        // backpressure: result held, new requests ignored
        out_ready = 1'b0;
        send(16'h1234, 16'h1111, 1'b0);
        wait_done(lat);
        check("bp_sum", sum, 16'h2345);
        for (int i = 0; i < 10; i++) begin
            tick();
            in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
            @(negedge clk);
            check("bp_hold", sum, 16'h2345);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
        end
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", in_ready, 1);
        tick();
        @(negedge clk);
        check("bp_consumed", out_valid, 0);
        check("bp_no_accept", busy, 0);

        // reset in the middle of a run, with a request during the reset cycle
        send(16'hABCD, 16'h1357, 1'b0);
        tick();
        tick();
        rst_n = 1'b0; in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
        tick();
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        check("mid_busy", busy, 0);
        check("mid_sum", sum, 16'h0000);
        check("mid_cout", cout, 0);
        check("mid_out_valid", out_valid, 0);
        check("mid_in_ready", in_ready, 1);
        @(negedge clk);
        check("mid_no_accept", busy, 0);
        send(16'h0005, 16'h0003, 1'b0);
        wait_done(lat);
        check("mid_next_sum", sum, 16'h0008);
        check("mid_next_cout", cout, 0);
        tick();

        // randomized traffic with stalls and rare resets
        for (int i = 0; i < 20000; i++) begin
            tick();
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = pick();
            b         = pick();
            cin       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 999) != 0);
        end
        tick();
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (10) tick();
        check("rand_results_seen", n_results > 1000, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
